// File: rtl/dvi_tx_tmds_encoder_if.sv
// Pixel-side signals of one TMDS lane: symbol request in, encoded 10-bit symbol out.
interface dvi_tx_tmds_encoder_if;
  logic       de;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic [9:0] tmds_data;

  modport master (output de, data, ctrl, input tmds_data);
  modport slave  (input de, data, ctrl, output tmds_data);
endinterface

// File: rtl/dvi_tx_tmds_encoder.sv
// DVI 1.0 TMDS encoder, one lane, 2-cycle latency (3 with DVI_TX_ENC_OUT_REG_EN defined).
// Stage 1 minimises transitions, stage 2 balances DC using a signed running disparity.
module dvi_tx_tmds_encoder #(
  parameter int DISP_WIDTH = 5
) (
  input logic                   pixel_clock,
  input logic                   reset,
  dvi_tx_tmds_encoder_if.slave  bus
);
  typedef logic signed [DISP_WIDTH-1:0] disp_t;

  localparam logic [9:0] CTRL_00 = 10'h354;
  localparam logic [9:0] CTRL_01 = 10'h0AB;
  localparam logic [9:0] CTRL_10 = 10'h154;
  localparam logic [9:0] CTRL_11 = 10'h2AB;
  localparam disp_t      ZERO    = disp_t'(0);
  localparam disp_t      TWO     = disp_t'(2);

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [8:0] min_trans(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n1;
    logic       use_xnor;
    n1       = popcnt8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q[0]     = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  logic       de_s1_d, de_s1_q;
  logic [1:0] ctrl_s1_d, ctrl_s1_q;
  logic [8:0] qm_s1_d, qm_s1_q;
  logic [9:0] tmds_d, tmds_q;
  disp_t      cnt_d, cnt_q;

  always_comb begin
    de_s1_d   = bus.de;
    ctrl_s1_d = bus.ctrl;
    qm_s1_d   = min_trans(bus.data);
  end

  logic [3:0] n1q, n0q;
  logic       qm8, cnt_pos, cnt_neg;
  disp_t      bal;

  always_comb begin
    n1q     = popcnt8(qm_s1_q[7:0]);
    n0q     = 4'd8 - n1q;
    qm8     = qm_s1_q[8];
    bal     = disp_t'(n1q) - disp_t'(n0q);
    cnt_neg = cnt_q[DISP_WIDTH-1];
    cnt_pos = !cnt_neg && (cnt_q != ZERO);
    tmds_d  = CTRL_00;
    cnt_d   = cnt_q;
    if (!de_s1_q) begin
      // blanking restarts the disparity so each active segment starts balanced
      unique case (ctrl_s1_q)
        2'b00: tmds_d = CTRL_00;
        2'b01: tmds_d = CTRL_01;
        2'b10: tmds_d = CTRL_10;
        2'b11: tmds_d = CTRL_11;
      endcase
      cnt_d = ZERO;
    end else if ((cnt_q == ZERO) || (n1q == n0q)) begin
      tmds_d = {~qm8, qm8, qm8 ? qm_s1_q[7:0] : ~qm_s1_q[7:0]};
      cnt_d  = qm8 ? (cnt_q + bal) : (cnt_q - bal);
    end else if ((cnt_pos && (n1q > n0q)) || (cnt_neg && (n0q > n1q))) begin
      tmds_d = {1'b1, qm8, ~qm_s1_q[7:0]};
      cnt_d  = cnt_q + (qm8 ? TWO : ZERO) - bal;
    end else begin
      tmds_d = {1'b0, qm8, qm_s1_q[7:0]};
      cnt_d  = cnt_q - (qm8 ? ZERO : TWO) + bal;
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      de_s1_q   <= 1'b0;
      ctrl_s1_q <= 2'b00;
      qm_s1_q   <= '0;
      tmds_q    <= CTRL_00;
      cnt_q     <= ZERO;
    end else begin
      de_s1_q   <= de_s1_d;
      ctrl_s1_q <= ctrl_s1_d;
      qm_s1_q   <= qm_s1_d;
      tmds_q    <= tmds_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef DVI_TX_ENC_OUT_REG_EN
  logic [9:0] out_d, out_q;

  always_comb out_d = tmds_q;

  always_ff @(posedge pixel_clock) begin
    if (reset) out_q <= CTRL_00;
    else       out_q <= out_d;
  end

  assign bus.tmds_data = out_q;
`else
  assign bus.tmds_data = tmds_q;
`endif
endmodule

// File: tb/tb_dvi_tx_tmds_encoder.sv
// Bench for dvi_tx_tmds_encoder: directed literal vectors plus a random soak checked
// every cycle against a symbol-level model of the DVI encoding rules.
module tb_dvi_tx_tmds_encoder;
`ifdef DVI_TX_ENC_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic pixel_clock = 1'b0;
  logic reset       = 1'b1;
  always #5 pixel_clock = ~pixel_clock;

  dvi_tx_tmds_encoder_if bus ();

  dvi_tx_tmds_encoder #(.DISP_WIDTH(5)) dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;

  // model state: inputs seen at the previous edge, running disparity, output pipe
  bit         p_rst   = 1'b1;
  bit         p_de    = 1'b0;
  logic [7:0] p_data  = '0;
  logic [1:0] p_ctrl  = '0;
  int         m_cnt   = 0;
  logic [9:0] e2_prev = 10'h354;
  bit         e2d_prev = 1'b0;
  logic [9:0] exp_out = 10'h354;
  bit         exp_data = 1'b0;
  int         seg = 0;
  int         lit_q[$];
  string      name_q[$];

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    case (c)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  // running disparity is simply the ones-minus-zeros tally of emitted data symbols
  function automatic logic [9:0] model_data(input logic [7:0] d);
    int         n1, bal;
    logic [7:0] qm;
    bit         xn, qm8;
    logic [9:0] o;
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm8 = !xn;
    bal = 2 * $countones(qm) - 8;
    if (m_cnt == 0 || bal == 0)           o = qm8 ? {2'b01, qm} : {2'b10, ~qm};
    else if ((m_cnt > 0) == (bal > 0))    o = {1'b1, qm8, ~qm};
    else                                  o = {1'b0, qm8, qm};
    m_cnt += 2 * $countones(o) - 10;
    return o;
  endfunction

  task automatic check(input string nm, input logic [9:0] got, input logic [9:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic step(input bit r, input bit d, input logic [7:0] dat, input logic [1:0] c,
                      input int lit, input string nm);
    logic [9:0] e2;
    bit         e2d;
    int         l;
    string      n;
    reset    = r;
    bus.de   = d;
    bus.data = dat;
    bus.ctrl = c;
    @(posedge pixel_clock);
    if (r) begin
      e2 = 10'h354; e2d = 1'b0; m_cnt = 0;
    end else if (p_rst || !p_de) begin
      e2 = p_rst ? 10'h354 : ctrl_code(p_ctrl); e2d = 1'b0; m_cnt = 0;
    end else begin
      e2 = model_data(p_data); e2d = 1'b1;
    end
    p_rst = r; p_de = d; p_data = dat; p_ctrl = c;
`ifdef DVI_TX_ENC_OUT_REG_EN
    exp_out  = r ? 10'h354 : e2_prev;
    exp_data = r ? 1'b0 : e2d_prev;
    e2_prev  = e2;
    e2d_prev = e2d;
`else
    exp_out  = e2;
    exp_data = e2d;
`endif
    @(negedge pixel_clock);
    check("model", bus.tmds_data, exp_out);
    if (exp_data) begin
      seg += 2 * $countones(bus.tmds_data) - 10;
      checks++;
      if (seg > 10 || seg < -10) begin
        errors++;
        $display("FAIL disparity got %0d exp within +-10 at %0t", seg, $time);
      end
    end else begin
      seg = 0;
    end
    lit_q.push_back(lit);
    name_q.push_back(nm);
    if (lit_q.size() == LAT) begin
      l = lit_q.pop_front();
      n = name_q.pop_front();
      if (l >= 0) check(n, bus.tmds_data, l[9:0]);
    end
  endtask

  initial begin
    bus.de = 1'b0; bus.data = '0; bus.ctrl = '0;
    @(negedge pixel_clock);

    repeat (3) begin
      step(1'b1, 1'b1, 8'hA5, 2'b00, -1, "");
      check("reset_hold", bus.tmds_data, 10'h354);
    end
    step(1'b0, 1'b1, 8'hA5, 2'b00, -1, "");
    check("reset_release", bus.tmds_data, 10'h354);

    step(1'b0, 1'b0, 8'h00, 2'b00, 10'h354, "ctrl00");
    step(1'b0, 1'b0, 8'h00, 2'b01, 10'h0AB, "ctrl01");
    step(1'b0, 1'b0, 8'h00, 2'b10, 10'h154, "ctrl10");
    step(1'b0, 1'b0, 8'h00, 2'b11, 10'h2AB, "ctrl11");

    step(1'b0, 1'b1, 8'h00, 2'b00, 10'h100, "zero_run0");
    step(1'b0, 1'b1, 8'h00, 2'b00, 10'h3FF, "zero_run1");
    step(1'b0, 1'b1, 8'h00, 2'b00, 10'h100, "zero_run2");
    step(1'b0, 1'b0, 8'h00, 2'b00, 10'h354, "blank_a");

    step(1'b0, 1'b1, 8'hFF, 2'b00, 10'h200, "ones_run0");
    step(1'b0, 1'b1, 8'hFF, 2'b00, 10'h0FF, "ones_run1");
    step(1'b0, 1'b0, 8'h00, 2'b00, 10'h354, "blank_b");

    step(1'b0, 1'b1, 8'h00, 2'b00, 10'h100, "clr_first");
    step(1'b0, 1'b0, 8'h00, 2'b00, 10'h354, "clr_blank");
    step(1'b0, 1'b1, 8'h00, 2'b00, 10'h100, "clr_again");
    repeat (LAT) step(1'b0, 1'b0, 8'h00, 2'b00, 10'h354, "flush");

    for (int k = 0; k < 10000; k++) begin
      bit         r, d;
      logic [7:0] dat;
      logic [1:0] c;
      r   = ($urandom_range(199) == 0);
      d   = ($urandom_range(3) != 0);
      dat = 8'($urandom);
      c   = 2'($urandom);
      step(r, d, dat, c, -1, "");
    end
    repeat (LAT) step(1'b0, 1'b0, 8'h00, 2'b00, -1, "");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
